// File: rtl/ami_spi_pkg.sv
// Shared constants and state encoding for the AMI SPI responder.
// Frame layout on the wire, MSB first: R/Wn, address, data.
package ami_spi_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int CMD_BITS       = 1 + DEF_ADDR_WIDTH;
  localparam int FRAME_BITS     = CMD_BITS + DEF_DATA_WIDTH;
  localparam logic RW_READ      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE_WAIT = 2'd0,
    ST_IDLE      = 2'd1,
    ST_CMD       = 2'd2,
    ST_DATA      = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and
// produces SCLK edge pulses aligned with the delayed CSB/SDI levels.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic csb_i,
  input  logic sdi_i,
  output logic csb_o,
  output logic sdi_o,
  output logic sclkRise_o,
  output logic sclkFall_o
);

  // Bit 2 = SCLK, bit 1 = CSB, bit 0 = SDI.
  logic [2:0] chain_q [SYNC_STAGES];
  logic [2:0] prev_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      prev_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      chain_q[0] <= {sclk_i, csb_i, sdi_i};
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[SYNC_STAGES-1];
      rise_q <= chain_q[SYNC_STAGES-1][2] & ~prev_q[2];
      fall_q <= ~chain_q[SYNC_STAGES-1][2] & prev_q[2];
    end
  end

  assign csb_o      = prev_q[1];
  assign sdi_o      = prev_q[0];
  assign sclkRise_o = rise_q;
  assign sclkFall_o = fall_q;

endmodule

// File: rtl/ami_spi_responder.sv
// SPI mode-0 responder: decodes R/Wn+address+data frames into register
// write/read strobes and returns read data on SDO.
module ami_spi_responder
  import ami_spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 2
) (
  input  logic                  sysClk,
  input  logic                  sysReset,
  input  logic                  spiClk,
  input  logic                  spiCSB,
  input  logic                  spiSDI,
  output logic                  spiSDO,
  output logic                  spiSDOEnable,
  output logic                  wrStrobe,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [DATA_WIDTH-1:0] wrData,
  output logic                  rdStrobe,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  input  logic [DATA_WIDTH-1:0] rdData,
  output logic                  frameError,
  output logic                  busy
);

  localparam int FrameLen = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CmdLen   = 1 + ADDR_WIDTH;
  localparam int CntW     = $clog2(FrameLen + 2);
  localparam logic [CntW-1:0] CntFrame   = CntW'(FrameLen);
  localparam logic [CntW-1:0] CntSat     = CntW'(FrameLen + 1);
  localparam logic [CntW-1:0] CntCmdLast = CntW'(CmdLen - 1);

  logic csbHigh, sdiBit, sclkRise, sclkFall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) uPinSync (
    .clk_i      (sysClk),
    .rst_i      (sysReset),
    .sclk_i     (spiClk),
    .csb_i      (spiCSB),
    .sdi_i      (spiSDI),
    .csb_o      (csbHigh),
    .sdi_o      (sdiBit),
    .sclkRise_o (sclkRise),
    .sclkFall_o (sclkFall)
  );

  spi_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [FrameLen-1:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  isRead_q, isRead_d;
  logic                  sdo_q, sdo_d, sdoEn_q, sdoEn_d;
  logic                  wrStrobe_q, wrStrobe_d, rdStrobe_q, rdStrobe_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d, rdAddr_q, rdAddr_d;
  logic [DATA_WIDTH-1:0] wrData_q, wrData_d;
  logic                  frameErr_q, frameErr_d, busy_q, busy_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      state_q    <= ST_IDLE_WAIT;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      isRead_q   <= 1'b0;
      sdo_q      <= 1'b0;
      sdoEn_q    <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdStrobe_q <= 1'b0;
      rdAddr_q   <= '0;
      frameErr_q <= 1'b0;
      busy_q     <= 1'b0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      isRead_q   <= isRead_d;
      sdo_q      <= sdo_d;
      sdoEn_q    <= sdoEn_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      rdStrobe_q <= rdStrobe_d;
      rdAddr_q   <= rdAddr_d;
      frameErr_q <= frameErr_d;
      busy_q     <= busy_d;
      pipe_q     <= pipe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    isRead_d   = isRead_q;
    sdo_d      = sdo_q;
    sdoEn_d    = sdoEn_q;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    rdStrobe_d = 1'b0;
    rdAddr_d   = rdAddr_q;
    frameErr_d = 1'b0;
    pipe_d     = pipe_q << 1;
    pipe_d[0]  = rdStrobe_q;

    if (pipe_q[RD_LATENCY-1]) tx_d = rdData;

    unique case (state_q)
      ST_IDLE_WAIT: if (csbHigh) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!csbHigh) begin
          state_d  = ST_CMD;
          cnt_d    = '0;
          rx_d     = '0;
          isRead_d = 1'b0;
        end
      end
      default: begin
        // CSB rising is checked first so a coincident SCLK edge is dropped.
        if (csbHigh) begin
          state_d = ST_IDLE;
          sdo_d   = 1'b0;
          sdoEn_d = 1'b0;
          if (cnt_q == CntFrame) begin
            if (!isRead_q) begin
              wrStrobe_d = 1'b1;
              wrAddr_d   = rx_q[FrameLen-2 -: ADDR_WIDTH];
              wrData_d   = rx_q[DATA_WIDTH-1:0];
            end
          end else begin
            frameErr_d = 1'b1;
          end
        end else begin
          if (sclkRise) begin
            if (cnt_q < CntFrame) rx_d = {rx_q[FrameLen-2:0], sdiBit};
            if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
            if (state_q == ST_CMD && cnt_q == CntCmdLast) begin
              state_d  = ST_DATA;
              isRead_d = (rx_q[CmdLen-2] == RW_READ);
              sdoEn_d  = isRead_d;
              if (isRead_d) begin
                rdStrobe_d = 1'b1;
                rdAddr_d   = {rx_q[ADDR_WIDTH-2:0], sdiBit};
              end
            end
          end
          if (sclkFall && state_q == ST_DATA && isRead_q) begin
            sdo_d = tx_q[DATA_WIDTH-1];
            tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    endcase

    busy_d = (state_d == ST_CMD) || (state_d == ST_DATA);
  end

  assign spiSDO       = sdo_q;
  assign spiSDOEnable = sdoEn_q;
  assign wrStrobe     = wrStrobe_q;
  assign wrAddr       = wrAddr_q;
  assign wrData       = wrData_q;
  assign rdStrobe     = rdStrobe_q;
  assign rdAddr       = rdAddr_q;
  assign frameError   = frameErr_q;
  assign busy         = busy_q;

endmodule
